// File: rtl/alu_op_defs.sv
// Shared ALU opcode constants, commit classes and writeback FSM encoding.
// Used by both the ALU and its result writeback stage.
package alu_op_defs;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_SHL  = 5'b00001;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00010;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b00011;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_XOR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b01000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b01001;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b01010;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01100;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01101;
  localparam logic [OP_W-1:0] OP_IN   = 5'b01110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b01111;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b10000;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b10001;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b10010;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b10011;
  localparam logic [OP_W-1:0] OP_MOV  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11110;

  typedef enum logic [2:0] {
    CLS_LO_WR,
    CLS_HILO,
    CLS_HI_WR,
    CLS_OUT,
    CLS_ILLEGAL
  } opClass_t;

  typedef enum logic {
    ST_IDLE,
    ST_COMMIT
  } wbState_t;

endpackage

// File: rtl/alu_op_classify.sv
// Combinational opcode decode: which architectural state a result commits to,
// and whether it refreshes the carry flag.
module alu_op_classify
  import alu_op_defs::*;
(
  input  logic [OP_W-1:0] opCode,
  output opClass_t        opClass,
  output logic            carryUpdate
);

  always_comb begin
    opClass     = CLS_ILLEGAL;
    carryUpdate = 1'b0;
    case (opCode)
      OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NEG,
      OP_IN, OP_LDI, OP_ANDI, OP_ORI, OP_MOV: opClass = CLS_LO_WR;
      OP_ADD, OP_SUB, OP_ADDI: begin
        opClass     = CLS_LO_WR;
        carryUpdate = 1'b1;
      end
      OP_MUL, OP_DIV: opClass = CLS_HILO;
      OP_MFHI:        opClass = CLS_HI_WR;
      OP_OUT:         opClass = CLS_OUT;
      default:        opClass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_result_writeback.sv
// Commits ALU {HI,LO} results to the register file, HI/LO, OUT and carry state.
// Results are decoded on acceptance so the registered effects are present during COMMIT.
module alu_result_writeback
  import alu_op_defs::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [OP_W-1:0]     opcode,
  input  logic [RADDR_W-1:0]  dest_reg,
  input  logic [2*DATA_W-1:0] res_z,
  output logic                rf_we,
  output logic [RADDR_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [DATA_W-1:0]   hi_q,
  output logic [DATA_W-1:0]   lo_q,
  output logic [DATA_W-1:0]   out_q,
  output logic                carry_q,
  output logic                illegal
);

  wbState_t          state;
  opClass_t          opClass;
  logic              carryUpdate;
  logic              xfer;
  logic [DATA_W-1:0] zHi;
  logic [DATA_W-1:0] zLo;

  alu_op_classify uClassify (
    .opCode      (opcode),
    .opClass     (opClass),
    .carryUpdate (carryUpdate)
  );

  assign res_ready = (state == ST_IDLE) & ~clear;
  assign xfer      = res_valid & res_ready;
  assign zHi       = res_z[2*DATA_W-1:DATA_W];
  assign zLo       = res_z[DATA_W-1:0];

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= ST_IDLE;
      rf_we    <= 1'b0;
      illegal  <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      out_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      rf_we   <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            state <= ST_COMMIT;
            case (opClass)
              CLS_LO_WR: begin
                rf_we    <= 1'b1;
                rf_waddr <= dest_reg;
                rf_wdata <= zLo;
                // Carry out of add/sub lands in bit 0 of the HI half.
                if (carryUpdate) carry_q <= res_z[DATA_W];
              end
              CLS_HILO: begin
                hi_q <= zHi;
                lo_q <= zLo;
              end
              CLS_HI_WR: begin
                rf_we    <= 1'b1;
                rf_waddr <= dest_reg;
                rf_wdata <= zHi;
              end
              CLS_OUT: out_q   <= zLo;
              default: illegal <= 1'b1;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
